pipe_sequencer: RTL
===================

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have ports, clock and reset first:
- sysclk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- inst_valid  in  1  fetch offers an instruction
- inst_ready  out  1  sequencer accepts the offered instruction this cycle
- inst_op  in  3  opcode: ADD=0, ADDI=4, SW=5, LW=6, SLL=7
- inst_rd, inst_rs1, inst_rs2  in  3 each  register indices
- mem_busy  in  1  data memory not finished with the access in MEM
- ex_valid  out  1  EX stage holds a real instruction
- ex_op  out  3  opcode in EX (drives the ALU decode)
- mem_we  out  1  SW in MEM
- mem_re  out  1  LW in MEM
- wb_en  out  1  register-file write this cycle
- wb_rd  out  3  register-file write index
- stall  out  1  ID held by a data hazard this cycle
- illegal_op  out  1  one-cycle pulse: opcode 1, 2 or 3 accepted
- retired  out  16  count of instructions leaving WB
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL keep stage registers ID, EX, MEM, WB, each holding valid, op, rd, rs1, rs2.
REQ-004 Writers: ADD, ADDI, LW, SLL. Sources: ADD/SW/SLL read rs1 and rs2; ADDI/LW read rs1 only.
REQ-005 Accepted opcodes 1-3 SHALL enter ID as bubbles (valid=0) and pulse illegal_op the following cycle.
REQ-006 freeze = MEM.valid AND (MEM.op is LW or SW) AND mem_busy.
REQ-007 inst_ready = NOT ID.valid OR (NOT freeze AND NOT stall), combinational.
REQ-008 Per edge:
- WB <= freeze ? bubble : MEM.
- MEM <= freeze ? hold : EX.
- EX <= freeze ? hold : (stall ? bubble : ID).
- ID <= freeze or stall ? hold : (inst_valid and inst_ready ? new : bubble).
REQ-009 Latency: an instruction accepted at edge N SHALL be in EX after edge N+1, MEM after N+2 and WB after N+3, with no stall or freeze.
REQ-010 ex_valid/ex_op, mem_we, mem_re, wb_en and wb_rd SHALL decode directly from stage registers.
- mem_we = MEM.valid AND op==SW; mem_re likewise for LW; both stay high through freeze.
- wb_en = WB.valid AND WB.op is a writer; wb_rd = WB.rd.
REQ-011 retired SHALL increment on each cycle with WB.valid=1 and wrap 0xFFFF->0x0000.
REQ-012 When stall and freeze are both true, freeze SHALL take precedence and EX SHALL hold, not bubble.
REQ-013 A bubble SHALL never assert mem_we, mem_re or wb_en.

Reset
REQ-014 On rst=1 at an edge, all stage valids SHALL be cleared (ops, indices -> 0) regardless of freeze or stall, and in-flight instructions SHALL be discarded.
REQ-015 After reset: ex_valid=0, ex_op=0, mem_we=0, mem_re=0, wb_en=0, wb_rd=0, stall=0, illegal_op=0, retired=0, inst_ready=1.

Configuration
REQ-016 Macro PIPE_SEQ_FORWARDING_EN defined: stall = ID.valid AND EX.valid AND EX.op==LW AND EX.rd matches an ID source (one bubble per load-use).
REQ-017 Macro undefined: stall = ID.valid AND any of EX/MEM/WB is valid, a writer, and its rd matches an ID source.

Verification
REQ-018 The bench SHALL cover:
- ADD r1,r2,r3 then ADDI r4,r5 back-to-back, mem_busy=0 -> wb_en with wb_rd=1, then wb_rd=4 on consecutive cycles, 4 cycles after accept; retired=2.
- LW r2 then ADD r3,r2,r1, forwarding on -> stall=1 for exactly 1 cycle; ADD reaches WB 1 cycle later than without the hazard. Forwarding off -> stall=1 for 3 cycles.
- SW in MEM with mem_busy=1 for 3 cycles -> mem_we held 3+1 cycles, inst_ready=0, EX/ID contents unchanged, WB bubbles (wb_en=0).
- Opcode 2 accepted -> illegal_op pulses once; no wb_en, mem_we or mem_re for it; retired unchanged.
- rst asserted during freeze with 3 instructions in flight -> next cycle all valids 0, retired=0, inst_ready=1.
- retired preloaded by running 65535 instructions, then one more -> retired=0x0000.

Source files
------------

// File: rtl/pipe_sequencer.sv
// pipe_sequencer
// Control sequencer for a four-stage in-order pipeline (ID, EX, MEM, WB).
// It tracks which instruction sits in each stage, holds the pipe while a
// data-memory access is outstanding (freeze), inserts bubbles for register
// hazards (stall), and counts retirements.
//
// Build option: define PIPE_SEQ_FORWARDING_EN when the datapath forwards
// results; only a load immediately followed by a consumer then needs a
// bubble. With the macro undefined, any in-flight writer whose rd matches
// a source of the instruction in ID holds ID until that writer has left WB.
module pipe_sequencer (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [2:0]  inst_op,
  input  logic [2:0]  inst_rd,
  input  logic [2:0]  inst_rs1,
  input  logic [2:0]  inst_rs2,
  input  logic        mem_busy,
  output logic        ex_valid,
  output logic [2:0]  ex_op,
  output logic        mem_we,
  output logic        mem_re,
  output logic        wb_en,
  output logic [2:0]  wb_rd,
  output logic        stall,
  output logic        illegal_op,
  output logic [15:0] retired
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_LW   = 3'd6;
  localparam logic [2:0] OP_SLL  = 3'd7;

  // Opcodes that write the register file.
  function automatic logic is_writer(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SLL);
  endfunction

  // Opcodes that read rs2 in addition to rs1.
  function automatic logic reads_rs2(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SW) || (op == OP_SLL);
  endfunction

  // Unassigned opcode values; they travel as bubbles.
  function automatic logic is_illegal(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
  endfunction

  // True when a producer's rd is one of the sources the consumer reads.
  function automatic logic src_hit(input logic [2:0] prod_rd,
                                   input logic [2:0] cons_op,
                                   input logic [2:0] cons_rs1,
                                   input logic [2:0] cons_rs2);
    return (prod_rd == cons_rs1) || (reads_rs2(cons_op) && (prod_rd == cons_rs2));
  endfunction

  // p0 = ID, p1 = EX, p2 = MEM, p3 = WB
  logic        vld_p0, vld_p1, vld_p2, vld_p3;
  logic [2:0]  op_p0,  op_p1,  op_p2,  op_p3;
  logic [2:0]  rd_p0,  rd_p1,  rd_p2,  rd_p3;
  logic [2:0]  rs1_p0, rs1_p1, rs1_p2, rs1_p3;
  logic [2:0]  rs2_p0, rs2_p1, rs2_p2, rs2_p3;

  logic        freeze;
  logic        accept;
  logic        load_new;
  logic        unused_src_bits;

  // Memory still owns the load/store in MEM: nothing in the pipe may move.
  assign freeze = vld_p2 && ((op_p2 == OP_LW) || (op_p2 == OP_SW)) && mem_busy;

`ifdef PIPE_SEQ_FORWARDING_EN
  // Only a load in EX cannot forward in time; one bubble resolves it.
  assign stall = vld_p0 && vld_p1 && (op_p1 == OP_LW) &&
                 src_hit(rd_p1, op_p0, rs1_p0, rs2_p0);
`else
  // Without forwarding, ID waits until every matching writer has left WB.
  assign stall = vld_p0 && (
                   (vld_p1 && is_writer(op_p1) && src_hit(rd_p1, op_p0, rs1_p0, rs2_p0)) ||
                   (vld_p2 && is_writer(op_p2) && src_hit(rd_p2, op_p0, rs1_p0, rs2_p0)) ||
                   (vld_p3 && is_writer(op_p3) && src_hit(rd_p3, op_p0, rs1_p0, rs2_p0)));
`endif

  assign inst_ready = !vld_p0 || (!freeze && !stall);
  assign accept     = inst_valid && inst_ready;
  assign load_new   = accept && !is_illegal(inst_op);

  // Source indices travel with each instruction for visibility in later
  // stages; nothing past ID decodes them.
  assign unused_src_bits = ^{rs1_p1, rs2_p1, rs1_p2, rs2_p2, rs1_p3, rs2_p3, rd_p2};

  // ID stage: capture a new instruction, a bubble, or hold under freeze/stall
  always_ff @(posedge sysclk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      op_p0  <= 3'd0;
      rd_p0  <= 3'd0;
      rs1_p0 <= 3'd0;
      rs2_p0 <= 3'd0;
    end else if (!(freeze || stall)) begin
      if (load_new) begin
        vld_p0 <= 1'b1;
        op_p0  <= inst_op;
        rd_p0  <= inst_rd;
        rs1_p0 <= inst_rs1;
        rs2_p0 <= inst_rs2;
      end else begin
        vld_p0 <= 1'b0;
        op_p0  <= 3'd0;
        rd_p0  <= 3'd0;
        rs1_p0 <= 3'd0;
        rs2_p0 <= 3'd0;
      end
    end
  end

  // EX stage: hold under freeze (freeze wins over stall), bubble on stall
  always_ff @(posedge sysclk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      op_p1  <= 3'd0;
      rd_p1  <= 3'd0;
      rs1_p1 <= 3'd0;
      rs2_p1 <= 3'd0;
    end else if (!freeze) begin
      if (stall) begin
        vld_p1 <= 1'b0;
        op_p1  <= 3'd0;
        rd_p1  <= 3'd0;
        rs1_p1 <= 3'd0;
        rs2_p1 <= 3'd0;
      end else begin
        vld_p1 <= vld_p0;
        op_p1  <= op_p0;
        rd_p1  <= rd_p0;
        rs1_p1 <= rs1_p0;
        rs2_p1 <= rs2_p0;
      end
    end
  end

  // MEM stage: hold the access while memory is busy
  always_ff @(posedge sysclk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      op_p2  <= 3'd0;
      rd_p2  <= 3'd0;
      rs1_p2 <= 3'd0;
      rs2_p2 <= 3'd0;
    end else if (!freeze) begin
      vld_p2 <= vld_p1;
      op_p2  <= op_p1;
      rd_p2  <= rd_p1;
      rs1_p2 <= rs1_p1;
      rs2_p2 <= rs2_p1;
    end
  end

  // WB stage: bubble while MEM is frozen so nothing retires twice
  always_ff @(posedge sysclk) begin
    if (rst) begin
      vld_p3 <= 1'b0;
      op_p3  <= 3'd0;
      rd_p3  <= 3'd0;
      rs1_p3 <= 3'd0;
      rs2_p3 <= 3'd0;
    end else if (freeze) begin
      vld_p3 <= 1'b0;
      op_p3  <= 3'd0;
      rd_p3  <= 3'd0;
      rs1_p3 <= 3'd0;
      rs2_p3 <= 3'd0;
    end else begin
      vld_p3 <= vld_p2;
      op_p3  <= op_p2;
      rd_p3  <= rd_p2;
      rs1_p3 <= rs1_p2;
      rs2_p3 <= rs2_p2;
    end
  end

  // Illegal-opcode pulse, one cycle after the offending accept
  always_ff @(posedge sysclk) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept && is_illegal(inst_op);
    end
  end

  // Retirement counter: one per valid instruction leaving WB, wraps naturally
  always_ff @(posedge sysclk) begin
    if (rst) begin
      retired <= 16'd0;
    end else if (vld_p3) begin
      retired <= retired + 16'd1;
    end
  end

  assign ex_valid = vld_p1;
  assign ex_op    = op_p1;
  assign mem_we   = vld_p2 && (op_p2 == OP_SW);
  assign mem_re   = vld_p2 && (op_p2 == OP_LW);
  assign wb_en    = vld_p3 && is_writer(op_p3);
  assign wb_rd    = rd_p3;

endmodule
